// File: rtl/matrix_loader_pkg.sv
// Shared types and helpers for the matrix loader: FSM states, error codes, size limits.
// The optional parity feature is selected with the LOADER_PARITY_EN macro in matrix_loader.
package matrix_loader_pkg;

    localparam int LOADER_MAX_N = 32;
    localparam int LOADER_CNT_W = 11;

    typedef enum logic [2:0] {
        L_IDLE,
        L_LOAD_A,
        L_LOAD_B,
        L_KICK,
        L_ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        LE_NONE,
        LE_BAD_N,
        LE_ADDR_OVF,
        LE_PARITY
    } loader_err_t;

    // True when a region of `words` starting at `base` runs past the top of a 2^aw memory.
    function automatic logic region_overflows(input logic [31:0] base,
                                              input logic [31:0] words,
                                              input int unsigned aw);
        return (base + words) > (32'd1 << aw);
    endfunction

endpackage

// File: rtl/matrix_addr_gen.sv
// Element index counter for one matrix phase: produces base+idx and flags the last word.
// The index wraps to zero on the last step so the next phase starts without a bubble.
module matrix_addr_gen
    import matrix_loader_pkg::*;
#(
    parameter int AW = 12,
    parameter int CW = LOADER_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    input  logic [AW-1:0] base,
    input  logic [CW-1:0] nn,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [CW-1:0] idx_q;
    logic [CW-1:0] idx_d;

    assign addr = base + AW'(idx_q);
    assign last = (idx_q == (nn - 1'b1));

    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (step) begin
            idx_d = last ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Host-to-memory loader: streams matrix A then B (n*n words each) into memory, then kicks
// the controller. Define LOADER_PARITY_EN to add an even-parity MSB on in_data.
module matrix_loader
    import matrix_loader_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MAX_N = LOADER_MAX_N,
    parameter int AW    = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                abort,
    input  logic [8:0]          n,
    input  logic [AW-1:0]       addr_A,
    input  logic [AW-1:0]       addr_B,
    input  logic                in_valid,
`ifdef LOADER_PARITY_EN
    input  logic [WIDTH:0]      in_data,
`else
    input  logic [WIDTH-1:0]    in_data,
`endif
    output logic                in_ready,
    output logic [AW-1:0]       mem_addr,
    output logic [WIDTH-1:0]    mem_data,
    output logic                mem_wren,
    output logic                loader_busy,
    output logic                start_out,
    output logic [1:0]          err,
    output logic [10:0]         words_done,
    output loader_state_t       dbg_state_o
);

    localparam int CW = LOADER_CNT_W;

    loader_state_t     state_q;
    loader_err_t       err_q;
    logic [17:0]       nn_q;
    logic [CW-1:0]     nn_load_q;
    logic [AW-1:0]     addr_a_q;
    logic [AW-1:0]     addr_b_q;
    logic [AW-1:0]     mem_addr_q;
    logic [WIDTH-1:0]  mem_data_q;
    logic              mem_wren_q;
    logic              start_q;
    logic [10:0]       words_done_q;

    logic              loading;
    logic              accept;
    logic              parity_ok;
    logic              bad_n;
    logic              addr_ovf;
    logic [AW-1:0]     gen_base;
    logic [AW-1:0]     gen_addr;
    logic              gen_last;

    // Handshake: a word transfers on a cycle where in_valid and in_ready are both high.
    // in_ready is high only while loading and drops in the same cycle as an abort, so an
    // aborting cycle never consumes a host word.
    assign loading  = (state_q == L_LOAD_A) || (state_q == L_LOAD_B);
    assign in_ready = loading && !abort;
    assign accept   = in_valid && in_ready;

`ifdef LOADER_PARITY_EN
    assign parity_ok = ~(^in_data);
`else
    assign parity_ok = 1'b1;
`endif

    // Size checks use n*n registered last cycle, so n must be stable one cycle before load.
    assign bad_n    = (n == 9'd0) || (32'(n) > 32'(MAX_N));
    assign addr_ovf = region_overflows(32'(addr_A), 32'(nn_q), AW)
                   || region_overflows(32'(addr_B), 32'(nn_q), AW);
    assign gen_base = (state_q == L_LOAD_B) ? addr_b_q : addr_a_q;

    matrix_addr_gen #(
        .AW (AW),
        .CW (CW)
    ) u_addr_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (!loading),
        .step  (accept && parity_ok),
        .base  (gen_base),
        .nn    (nn_load_q),
        .addr  (gen_addr),
        .last  (gen_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= L_IDLE;
            err_q        <= LE_NONE;
            nn_q         <= '0;
            nn_load_q    <= '0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_wren_q   <= 1'b0;
            start_q      <= 1'b0;
            words_done_q <= '0;
        end else begin
            mem_wren_q <= 1'b0;
            start_q    <= 1'b0;
            nn_q       <= {9'd0, n} * {9'd0, n};
            if (abort) begin
                state_q <= L_IDLE;
            end else begin
                case (state_q)
                    L_IDLE, L_ERROR: begin
                        if (load) begin
                            if (bad_n) begin
                                state_q <= L_ERROR;
                                err_q   <= LE_BAD_N;
                            end else if (addr_ovf) begin
                                state_q <= L_ERROR;
                                err_q   <= LE_ADDR_OVF;
                            end else begin
                                state_q      <= L_LOAD_A;
                                err_q        <= LE_NONE;
                                words_done_q <= '0;
                                addr_a_q     <= addr_A;
                                addr_b_q     <= addr_B;
                                nn_load_q    <= nn_q[CW-1:0];
                            end
                        end
                    end
                    L_LOAD_A, L_LOAD_B: begin
                        if (accept) begin
                            if (!parity_ok) begin
                                state_q <= L_ERROR;
                                err_q   <= LE_PARITY;
                            end else begin
                                mem_wren_q   <= 1'b1;
                                mem_addr_q   <= gen_addr;
                                mem_data_q   <= in_data[WIDTH-1:0];
                                // 11 bits wraps at n=32 (2048 words); the count is informational.
                                words_done_q <= words_done_q + 11'd1;
                                if (gen_last) begin
                                    state_q <= (state_q == L_LOAD_A) ? L_LOAD_B : L_KICK;
                                end
                            end
                        end
                    end
                    L_KICK: begin
                        start_q <= 1'b1;
                        state_q <= L_IDLE;
                    end
                    default: state_q <= L_IDLE;
                endcase
            end
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;
    assign loader_busy = loading || (state_q == L_KICK);
    assign start_out   = start_q;
    assign err         = err_q;
    assign words_done  = words_done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: memory model on the falling edge, expected-write queue,
// assertion-based checks and one summary line.
module tb_matrix_loader;
    import matrix_loader_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic          abort = 1'b0;
    logic [8:0]    n = '0;
    logic [11:0]   addr_A = '0;
    logic [11:0]   addr_B = '0;
    logic          in_valid = 1'b0;
`ifdef LOADER_PARITY_EN
    logic [16:0]   in_data = '0;
    logic          corrupt = 1'b0;
`else
    logic [15:0]   in_data = '0;
`endif
    logic          in_ready;
    logic [11:0]   mem_addr;
    logic [15:0]   mem_data;
    logic          mem_wren;
    logic          loader_busy;
    logic          start_out;
    logic [1:0]    err;
    logic [10:0]   words_done;
    loader_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int start_cnt = 0;
    logic [27:0] exp_q[$];
    logic [15:0] mem_model [0:4095];

    matrix_loader dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .abort       (abort),
        .n           (n),
        .addr_A      (addr_A),
        .addr_B      (addr_B),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .loader_busy (loader_busy),
        .start_out   (start_out),
        .err         (err),
        .words_done  (words_done),
        .dbg_state_o (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: memory samples on the falling edge, writes must match exp_q in order
    always @(negedge clk) begin
        if (mem_wren) begin
            logic [27:0] got;
            got = {mem_addr, mem_data};
            wr_cnt++;
            mem_model[mem_addr] = mem_data;
            check("wr_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check("wr_addr_data", 64'(got), 64'(exp_q.pop_front()));
        end
        if (start_out) start_cnt++;
    end

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int nv, input int a, input int b);
        n = 9'(nv);
        addr_A = 12'(a);
        addr_B = 12'(b);
        tick();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
`ifdef LOADER_PARITY_EN
        in_data = {(^d) ^ corrupt, d};
`else
        in_data = d;
`endif
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_words(input int nv, input int a, input int b, input int k0,
                              input int cnt, input int d0, input bit gap);
        int nn;
        logic [11:0] ea;
        nn = nv * nv;
        for (int k = k0; k < k0 + cnt; k++) begin
            ea = (k < nn) ? 12'(a + k) : 12'(b + k - nn);
            exp_q.push_back({ea, 16'(d0 + k)});
            send_word(16'(d0 + k));
            if (gap) tick();
        end
    endtask

    task automatic check_region(input string tag, input int base, input int cnt, input int d0);
        int bad;
        bad = 0;
        for (int k = 0; k < cnt; k++) begin
            if (mem_model[12'(base + k)] !== 16'(d0 + k)) bad++;
        end
        check(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        int w0;
        int s0;
        // reset state
        #1;
        check("rst_outputs", {in_ready, mem_wren, loader_busy, start_out, err, words_done},
              64'd0);
        check("rst_state", 64'(dbg_state), 64'(L_IDLE));
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // n=4 continuous stream 1..32
        start_load(4, 12'h000, 12'h100);
        check("t1_state_a", 64'(dbg_state), 64'(L_LOAD_A));
        load_words(4, 12'h000, 12'h100, 0, 32, 1, 1'b0);
        check("t1_kick", {loader_busy, mem_wren, in_ready, start_out}, 64'b1100);
        check("t1_words_done", 64'(words_done), 64'd32);
        tick();
        check("t1_start", {start_out, loader_busy, mem_wren}, 64'b100);
        tick();
        check("t1_start_once", 64'(start_cnt), 64'd1);
        check_region("t1_memA", 12'h000, 16, 1);
        check_region("t1_memB", 12'h100, 16, 17);
        check("t1_writes", 64'(wr_cnt), 64'd32);

        // n=2 with in_valid every other cycle
        start_load(2, 12'h200, 12'h300);
        load_words(2, 12'h200, 12'h300, 0, 7, 50, 1'b1);
        check("t2_no_early_start", 64'(start_cnt), 64'd1);
        check("t2_busy", 64'(loader_busy), 64'd1);
        load_words(2, 12'h200, 12'h300, 7, 1, 50, 1'b1);
        tick();
        check("t2_start", 64'(start_cnt), 64'd2);
        check("t2_writes", 64'(wr_cnt), 64'd40);
        check_region("t2_memA", 12'h200, 4, 50);
        check_region("t2_memB", 12'h300, 4, 54);

        // illegal configurations
        w0 = wr_cnt;
        start_load(0, 12'h000, 12'h100);
        check("e_n0", {err, in_ready, loader_busy}, {2'd1, 2'b00});
        check("e_n0_state", 64'(dbg_state), 64'(L_ERROR));
        start_load(33, 12'h000, 12'h100);
        check("e_n33", 64'(err), 64'd1);
        start_load(4, 12'h000, 12'hFF5);
        check("e_ovf", 64'(err), 64'd2);
        tick();
        check("e_err_held", 64'(err), 64'd2);
        check("e_no_writes", 64'(wr_cnt), 64'(w0));

        // largest legal n is accepted, then abandoned
        start_load(32, 12'h000, 12'h400);
        check("n32_accept", {err, loader_busy}, {2'd0, 1'b1});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("n32_abort", 64'(dbg_state), 64'(L_IDLE));

        // abort after 5 words; B region ends exactly at the top of memory
        start_load(4, 12'h400, 12'hFF0);
        check("ab_boundary_ok", {err, loader_busy}, {2'd0, 1'b1});
        s0 = start_cnt;
        load_words(4, 12'h400, 12'hFF0, 0, 5, 200, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_outs", {loader_busy, in_ready, mem_wren}, 64'd0);
        check("ab_words_done", 64'(words_done), 64'd5);
        repeat (3) tick();
        check("ab_no_start", 64'(start_cnt), 64'(s0));
        check("ab_queue", 64'(exp_q.size()), 64'd0);
        check_region("ab_mem", 12'h400, 5, 200);

        // new load after abort
        start_load(1, 12'h500, 12'h501);
        load_words(1, 12'h500, 12'h501, 0, 2, 300, 1'b0);
        repeat (2) tick();
        check("rl_start", 64'(start_cnt), 64'(s0 + 1));
        check_region("rl_mem", 12'h500, 2, 300);

        // reset in LOAD_B
        start_load(3, 12'h600, 12'h700);
        load_words(3, 12'h600, 12'h700, 0, 11, 400, 1'b0);
        check("rs_pre", {in_ready, mem_wren}, 64'b11);
        check("rs_pre_state", 64'(dbg_state), 64'(L_LOAD_B));
        rst = 1'b1;
        #1;
        check("rs_outputs", {in_ready, mem_wren, loader_busy, start_out, err, words_done,
                             mem_addr, mem_data}, 64'd0);
        check("rs_state", 64'(dbg_state), 64'(L_IDLE));
        check("rs_lost_write", 64'(exp_q.size()), 64'd1);
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        s0 = start_cnt;
        start_load(3, 12'h600, 12'h700);
        load_words(3, 12'h600, 12'h700, 0, 18, 500, 1'b0);
        check("rs_words_done", 64'(words_done), 64'd18);
        repeat (2) tick();
        check("rs_start", 64'(start_cnt), 64'(s0 + 1));
        check_region("rs_memA", 12'h600, 9, 500);
        check_region("rs_memB", 12'h700, 9, 509);

`ifdef LOADER_PARITY_EN
        // bad parity on the third word
        w0 = wr_cnt;
        start_load(2, 12'h800, 12'h900);
        load_words(2, 12'h800, 12'h900, 0, 2, 600, 1'b0);
        corrupt = 1'b1;
        send_word(16'd602);
        corrupt = 1'b0;
        check("par_err", {err, in_ready, mem_wren}, {2'd3, 2'b00});
        check("par_state", 64'(dbg_state), 64'(L_ERROR));
        tick();
        check("par_writes", 64'(wr_cnt), 64'(w0 + 2));
        check_region("par_mem", 12'h800, 2, 600);
`endif

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
